// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-bus req/ack interface between the fetch unit and
//               instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_data_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_ack_i,
    input  ibus_data_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_ack_i,
    output ibus_data_i
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : IF stage - PC owner, instruction-bus req/ack master and
//               producer side of the IF/ID register. Optional ack watchdog
//               enabled by macro IFETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire  [5:0]           stall,
  input  wire                  flush,
  input  wire  [31:0]          new_pc,
  input  wire                  branch_flag_i,
  input  wire  [31:0]          branch_target_address_i,
  if_fetch_unit_if.master      ibus,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_inst,
  output logic                 stallreq,
  output logic                 fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_inst_buf,   w_inst_buf_nxt;
  logic [31:0] r_pc_buf,     w_pc_buf_nxt;
  logic        r_pend_br,    w_pend_br_nxt;
  logic [31:0] r_pend_tgt,   w_pend_tgt_nxt;
  logic        r_req,        w_req_nxt;
  logic [31:0] r_addr,       w_addr_nxt;
  logic        r_stallreq;
  logic [31:0] w_adv_pc;
  logic        w_ack;

`ifdef IFETCH_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_fetch_err, w_err_nxt;
  logic               w_unused;

  assign w_unused  = ^stall[5:1];
  assign fetch_err = r_fetch_err;
`else
  logic w_unused;

  assign w_unused  = ^{stall[5:1], TIMEOUT_CYCLES};
  assign fetch_err = 1'b0;
`endif

  assign w_ack = ibus.ibus_ack_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst_buf  <= 32'h0;
      r_pc_buf    <= 32'h0;
      r_pend_br   <= 1'b0;
      r_pend_tgt  <= 32'h0;
      r_req       <= 1'b0;
      r_addr      <= 32'h0;
      r_stallreq  <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_inst_buf  <= w_inst_buf_nxt;
      r_pc_buf    <= w_pc_buf_nxt;
      r_pend_br   <= w_pend_br_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
      r_req       <= w_req_nxt;
      r_addr      <= w_addr_nxt;
      r_stallreq  <= (w_state_nxt != S_HOLD);
`ifdef IFETCH_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
      r_fetch_err <= w_err_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_buf_nxt = r_inst_buf;
    w_pc_buf_nxt   = r_pc_buf;
    w_pend_br_nxt  = r_pend_br;
    w_pend_tgt_nxt = r_pend_tgt;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_adv_pc       = r_pc + 32'd4;
`ifdef IFETCH_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = 1'b0;
`endif

    if (branch_flag_i) begin
      w_adv_pc = branch_target_address_i;
    end else if (r_pend_br) begin
      w_adv_pc = r_pend_tgt;
    end

    if (flush) begin
      // An in-flight request cannot be aborted on the bus; let it drain.
      w_pc_nxt      = new_pc;
      w_pend_br_nxt = 1'b0;
      case (r_state)
        S_BUSY: begin
          if (w_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (branch_flag_i) begin
            w_pend_br_nxt  = 1'b1;
            w_pend_tgt_nxt = branch_target_address_i;
          end
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = S_BUSY;
`ifdef IFETCH_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
        S_BUSY: begin
          if (branch_flag_i) begin
            w_pend_br_nxt  = 1'b1;
            w_pend_tgt_nxt = branch_target_address_i;
          end
          if (w_ack) begin
            w_inst_buf_nxt = ibus.ibus_data_i;
            w_pc_buf_nxt   = r_pc;
            w_req_nxt      = 1'b0;
            w_state_nxt    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall[0]) begin
            w_pc_nxt      = w_adv_pc;
            w_pend_br_nxt = 1'b0;
            w_req_nxt     = 1'b1;
            w_addr_nxt    = w_adv_pc;
            w_state_nxt   = S_BUSY;
`ifdef IFETCH_TIMEOUT_EN
            w_cnt_nxt     = '0;
`endif
          end else if (branch_flag_i) begin
            w_pend_br_nxt  = 1'b1;
            w_pend_tgt_nxt = branch_target_address_i;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

`ifdef IFETCH_TIMEOUT_EN
    // Watchdog: a dead fetch turns into a NOP so the pipeline keeps moving.
    if ((r_state == S_BUSY || r_state == S_DRAIN) && !w_ack) begin
      if (r_cnt >= c_TMO_LAST) begin
        w_req_nxt = 1'b0;
        w_err_nxt = 1'b1;
        if (r_state == S_BUSY && !flush) begin
          w_state_nxt    = S_HOLD;
          w_inst_buf_nxt = 32'h0;
          w_pc_buf_nxt   = r_pc;
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end else begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ibus.ibus_req_o  = r_req;
  assign ibus.ibus_addr_o = r_addr;
  assign if_pc            = (r_state == S_HOLD) ? r_pc_buf   : 32'h0;
  assign if_inst          = (r_state == S_HOLD) ? r_inst_buf : 32'h0;
  assign stallreq         = r_stallreq;

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register; drives if_pc/if_inst and honours the ctrl stall vector and flush.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Raises stallreq while a fetch is outstanding so ctrl can bubble IF/ID.
- Redirects on flush (exception new_pc) and on branch (ID-resolved target).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with IFETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  ctrl stall vector; stall[0]=1 freezes PC advance.
- flush  in  1  pipeline flush; redirect to new_pc.
- new_pc  in  32  exception/ERET target, valid with flush.
- branch_flag_i  in  1  branch taken, from ID.
- branch_target_address_i  in  32  branch target, valid with branch_flag_i.
- ibus_req_o  out  1  fetch request, held until ack.
- ibus_addr_o  out  32  fetch address, stable while ibus_req_o=1.
- ibus_ack_i  in  1  one-cycle acknowledge; ibus_data_i valid with it.
- ibus_data_i  in  32  fetched instruction word.
- if_pc  out  32  PC of presented instruction, to IF/ID.
- if_inst  out  32  presented instruction; 0 when none valid.
- stallreq  out  1  fetch-not-ready request to ctrl.
- fetch_err  out  1  ack timeout pulse (IFETCH_TIMEOUT_EN only).

Behaviour:
- Internal state: pc, inst_buf, pc_buf, pend_br, pend_tgt. FSM states IDLE, BUSY, HOLD, DRAIN.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, pend_br=0. Outputs: ibus_req_o=0, ibus_addr_o=0, if_pc=0, if_inst=0, stallreq=0, fetch_err=0.
- IDLE: stallreq=1, if_inst=0, if_pc=0. Next edge: ibus_req_o<=1, ibus_addr_o<=pc, go BUSY.
- BUSY: ibus_req_o=1, address held, stallreq=1, if_inst=0.
  - ack and no flush: inst_buf<=ibus_data_i, pc_buf<=pc, drop req, go HOLD.
- HOLD: if_pc=pc_buf, if_inst=inst_buf, stallreq=0.
  - stall[0]=0: pc<=branch target if branch_flag_i or pend_br (live branch_flag_i wins), else pc+4 mod 2^32. Clear pend_br. Issue request at the new pc the same edge, go BUSY.
  - stall[0]=1: remain in HOLD; outputs stable.
- Throughput: one instruction per 2 cycles when ack returns the cycle after request. Latency reset-release to first valid if_inst = 2 cycles with zero-wait memory.
- branch_flag_i seen in IDLE/BUSY/HOLD-while-stalled: latch pend_br=1, pend_tgt. Consumed on the next advance. A later branch overwrites an earlier one.
- Flush has priority over everything. pc<=new_pc, pend_br<=0.
  - From IDLE/HOLD: go IDLE.
  - From BUSY without ack same cycle: go DRAIN.
  - From BUSY with ack same cycle: discard data, go IDLE.
- DRAIN: ibus_req_o held (no abort on bus), stallreq=1, if_inst=0. On ack discard data, go IDLE. Flush in DRAIN updates pc only.
- if_pc/if_inst are registered; never combinational from ibus_data_i.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With it: counter clears on each request and counts cycles in BUSY/DRAIN.
  - At TIMEOUT_CYCLES without ack: drop ibus_req_o, pulse fetch_err for 1 cycle.
  - From BUSY: go HOLD with inst_buf=0, pc_buf=pc (NOP).
  - From DRAIN: go IDLE.
  - A late ack for the dropped request is ignored.
- Without it: no counter; fetch_err tied 0; BUSY waits indefinitely.

Test Plan:
- Reset release, zero-wait ack, stall=0 -> addresses 0x0,0x4,0x8 requested; if_inst shows each word 1 cycle after ack; stallreq alternates 1/0.
- stall=6'b000011 in HOLD for 3 cycles -> no new req, if_pc/if_inst unchanged; on release next addr = pc_buf+4.
- branch_flag_i=1, target 0x100 while BUSY at 0x8 -> after HOLD advance next req addr 0x100, not 0xC.
- flush, new_pc=0x20, in BUSY, ack 3 cycles later -> DRAIN, data discarded, if_inst=0 throughout, next req addr 0x20.
- flush and ack same cycle -> discarded, IDLE, next req 0x20; rst low mid-BUSY -> all outputs 0 immediately, restart at RESET_PC.
- IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> fetch_err pulses 4 cycles after req, if_inst=0 in HOLD, next req pc+4.
